// File: rtl/count_capture_fifo.sv
// Snapshots count_in on each capture into a DEPTH-entry FIFO drained by a valid/ready sink.
// Latency: one cycle from capture to out_valid; a full FIFO drops captures unless popped that cycle.
// Backpressure: out_data holds while out_ready is low; drops are flagged and counted (saturating).
module count_capture_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int DROPW = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           count_in,
    input  logic                       capture,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    input  logic                       clear_overflow,
    output logic [DROPW-1:0]           drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0]    LVL_FULL = LW'(DEPTH);
    localparam logic [DROPW-1:0] DROP_MAX = '1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             overflow_q, overflow_d;
    logic [DROPW-1:0] drop_q, drop_d;

    logic pop, push, drop;

    // Status flags come only from registered level, never from capture/out_ready.
    assign full      = (level_q == LVL_FULL);
    assign empty     = (level_q == '0);
    assign out_valid = ~empty;
    assign out_data  = mem_q[rptr_q];
    assign level     = level_q;
    assign overflow  = overflow_q;
    assign drop_count = drop_q;

    assign pop  = out_valid & out_ready;
    assign push = capture & (~full | pop);
    assign drop = capture & full & ~pop;

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;

        // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
        if (push) wptr_d = wptr_q + 1'b1;
        if (pop)  rptr_d = rptr_q + 1'b1;

        if (push && !pop)      level_d = level_q + 1'b1;
        else if (pop && !push) level_d = level_q - 1'b1;

        if (clear_overflow) begin
            overflow_d = 1'b0;
            drop_d     = '0;
        end
        // A drop in the same cycle as a clear restarts the count at one.
        if (drop) begin
            overflow_d = 1'b1;
            if (clear_overflow)        drop_d = {{(DROPW-1){1'b0}}, 1'b1};
            else if (drop_q != DROP_MAX) drop_d = drop_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
            if (push) mem_q[wptr_q] <= count_in;
        end
    end

endmodule

// File: tb/tb_count_capture_fifo.sv
// Directed bench for count_capture_fifo: reset, latency, fill/drain, drops, clear, mid-run reset, wrap.
module tb_count_capture_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] count_in;
    logic       capture;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] level;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       clear_overflow;
    logic [7:0] drop_count;

    int tests_run    = 0;
    int tests_failed = 0;

    count_capture_fifo #(.WIDTH(8), .DEPTH(4), .DROPW(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .count_in       (count_in),
        .capture        (capture),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .level          (level),
        .full           (full),
        .empty          (empty),
        .overflow       (overflow),
        .clear_overflow (clear_overflow),
        .drop_count     (drop_count)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; count_in = '0; capture = 0; out_ready = 0; clear_overflow = 0;
        step(); step();
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %0b exp 0", out_valid); end
        tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL reset_empty got %0b exp 1", empty); end
        tests_run++; if (full !== 1'b0) begin tests_failed++; $display("FAIL reset_full got %0b exp 0", full); end
        tests_run++; if (out_data !== 8'h00) begin tests_failed++; $display("FAIL reset_data got %0h exp 0", out_data); end
        tests_run++; if (level !== 3'd0) begin tests_failed++; $display("FAIL reset_level got %0d exp 0", level); end
        tests_run++; if ({overflow, drop_count} !== 9'd0) begin tests_failed++; $display("FAIL reset_drop got ovf=%0b cnt=%0d exp 0/0", overflow, drop_count); end
        reset = 1'b1;
        step();
    endtask

    task automatic test_single();
        capture = 1; count_in = 8'h05;
        #1;
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL no_bypass got valid=%0b exp 0", out_valid); end
        step();
        capture = 0;
        tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL single_valid got %0b exp 1", out_valid); end
        tests_run++; if (out_data !== 8'h05) begin tests_failed++; $display("FAIL single_data got %0h exp 05", out_data); end
        tests_run++; if (level !== 3'd1) begin tests_failed++; $display("FAIL single_level got %0d exp 1", level); end
        out_ready = 1;
        step();
        out_ready = 0;
        tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL single_empty got %0b exp 1", empty); end
        tests_run++; if (level !== 3'd0) begin tests_failed++; $display("FAIL single_level0 got %0d exp 0", level); end
    endtask

    task automatic fill4(input logic [7:0] base);
        for (int i = 0; i < 4; i++) begin
            capture = 1; count_in = base + 8'(i);
            step();
        end
        capture = 0;
    endtask

    task automatic test_fill_drain();
        fill4(8'd10);
        tests_run++; if (full !== 1'b1) begin tests_failed++; $display("FAIL fill_full got %0b exp 1", full); end
        tests_run++; if (level !== 3'd4) begin tests_failed++; $display("FAIL fill_level got %0d exp 4", level); end
        step();
        tests_run++; if (out_data !== 8'd10) begin tests_failed++; $display("FAIL hold_stable got %0d exp 10", out_data); end
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (out_data !== 8'(10 + i)) begin tests_failed++; $display("FAIL drain_%0d got %0d exp %0d", i, out_data, 10 + i); end
            step();
        end
        out_ready = 0;
        tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL drain_empty got %0b exp 1", empty); end
    endtask

    task automatic test_drop_saturate();
        fill4(8'd10);
        capture = 1; count_in = 8'd20;
        step();
        capture = 0;
        tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL drop_ovf got %0b exp 1", overflow); end
        tests_run++; if (drop_count !== 8'd1) begin tests_failed++; $display("FAIL drop_cnt got %0d exp 1", drop_count); end
        tests_run++; if (level !== 3'd4 || out_data !== 8'd10) begin tests_failed++; $display("FAIL drop_unchanged got lvl=%0d data=%0d exp 4/10", level, out_data); end
        capture = 1;
        for (int i = 0; i < 300; i++) step();
        capture = 0;
        tests_run++; if (drop_count !== 8'd255) begin tests_failed++; $display("FAIL drop_sat got %0d exp 255", drop_count); end
        clear_overflow = 1;
        step();
        clear_overflow = 0;
        tests_run++; if ({overflow, drop_count} !== 9'd0) begin tests_failed++; $display("FAIL clear got ovf=%0b cnt=%0d exp 0/0", overflow, drop_count); end
    endtask

    // Entry point: FIFO holds 10..13 and is full.
    task automatic test_full_pop();
        capture = 1; count_in = 8'd30; out_ready = 1;
        step();
        capture = 0; out_ready = 0;
        tests_run++; if (level !== 3'd4) begin tests_failed++; $display("FAIL fullpop_level got %0d exp 4", level); end
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL fullpop_ovf got %0b exp 0", overflow); end
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            logic [7:0] exp_v;
            exp_v = (i == 3) ? 8'd30 : 8'(11 + i);
            tests_run++;
            if (out_data !== exp_v) begin tests_failed++; $display("FAIL fullpop_order_%0d got %0d exp %0d", i, out_data, exp_v); end
            step();
        end
        out_ready = 0;
    endtask

    task automatic test_clear_vs_drop();
        fill4(8'd1);
        capture = 1;
        step(); step(); step();
        tests_run++; if (drop_count !== 8'd3) begin tests_failed++; $display("FAIL pre_clear_cnt got %0d exp 3", drop_count); end
        clear_overflow = 1;
        step();
        capture = 0;
        tests_run++; if (overflow !== 1'b1 || drop_count !== 8'd1) begin tests_failed++; $display("FAIL clear_drop got ovf=%0b cnt=%0d exp 1/1", overflow, drop_count); end
        step();
        clear_overflow = 0;
        tests_run++; if (overflow !== 1'b0 || drop_count !== 8'd0) begin tests_failed++; $display("FAIL clear_alone got ovf=%0b cnt=%0d exp 0/0", overflow, drop_count); end
        out_ready = 1;
        step(); step(); step(); step();
        out_ready = 0;
    endtask

    task automatic test_reset_mid_and_wrap();
        for (int i = 0; i < 3; i++) begin
            capture = 1; count_in = 8'(40 + i);
            step();
        end
        capture = 0;
        tests_run++; if (level !== 3'd3) begin tests_failed++; $display("FAIL pre_reset_level got %0d exp 3", level); end
        #2 reset = 1'b0;
        #1;
        tests_run++; if (level !== 3'd0 || out_valid !== 1'b0 || out_data !== 8'd0) begin
            tests_failed++; $display("FAIL mid_reset got lvl=%0d vld=%0b data=%0d exp 0/0/0", level, out_valid, out_data);
        end
        step();
        reset = 1'b1;
        step();
        // Stream through the pointer wrap, then run at depth 3 to wrap with a fuller FIFO.
        for (int i = 0; i < 10; i++) begin
            capture = 1; count_in = 8'(50 + i); out_ready = 1;
            if (i > 0) begin
                tests_run++;
                if (out_data !== 8'(49 + i) || level !== 3'd1) begin tests_failed++; $display("FAIL wrap_%0d got data=%0d lvl=%0d exp %0d/1", i, out_data, level, 49 + i); end
            end
            step();
        end
        capture = 0;
        tests_run++; if (out_data !== 8'd59) begin tests_failed++; $display("FAIL wrap_last got %0d exp 59", out_data); end
        step();
        out_ready = 0;
        tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL wrap_empty got %0b exp 1", empty); end
        for (int i = 0; i < 3; i++) begin
            capture = 1; count_in = 8'(70 + i);
            step();
        end
        for (int i = 0; i < 6; i++) begin
            capture = 1; count_in = 8'(73 + i); out_ready = 1;
            tests_run++;
            if (out_data !== 8'(70 + i) || level !== 3'd3) begin tests_failed++; $display("FAIL wrap3_%0d got data=%0d lvl=%0d exp %0d/3", i, out_data, level, 70 + i); end
            step();
        end
        capture = 0; out_ready = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_drain();
        test_drop_saturate();
        test_full_pop();
        test_clear_vs_drop();
        test_reset_mid_and_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
